// File: rtl/booth_sched_pkg.sv
// Shared types and defaults for the round-robin Booth multiplier scheduler.
// Holds FSM states, Booth op encoding and the op-select helper.
package booth_sched_pkg;

    localparam int DEF_W    = 8;
    localparam int DEF_NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        NOP = 2'd0,
        ADD = 2'd1,
        SUB = 2'd2
    } booth_op_t;

    function automatic booth_op_t booth_op(
        input logic q0,
        input logic q_1
    );
        booth_op_t op;
        unique case ({q0, q_1})
            2'b10:   op = SUB;
            2'b01:   op = ADD;
            default: op = NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/sub of the multiplicand, then an
// arithmetic right shift of {A,Q,q_1}.
module booth_step
    import booth_sched_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W:0]   a,
    input  logic [W-1:0] q,
    input  logic         q_1,
    input  logic [W-1:0] m,
    output logic [W:0]   a_next,
    output logic [W-1:0] q_next,
    output logic         q_1_next
);

    logic [W:0] m_ext;
    logic [W:0] sum;

    // A is one bit wider so that -2^(W-1) as M cannot overflow
    assign m_ext = {m[W-1], m};

    always_comb begin
        sum = a;
        unique case (booth_op(q[0], q_1))
            ADD:     sum = a + m_ext;
            SUB:     sum = a - m_ext;
            default: sum = a;
        endcase
    end

    assign a_next   = {sum[W], sum[W:1]};
    assign q_next   = {sum[0], q[W-1:1]};
    assign q_1_next = q[0];

endmodule

// File: rtl/booth_mult_scheduler.sv
// Round-robin front end sharing one iterative Booth multiplier among
// NREQ requesters; product is held with its requester id until taken.
module booth_mult_scheduler
    import booth_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*W-1:0]    rsp_prod,
    output logic [IDW-1:0]    rsp_id,
    output logic              busy
);

    localparam int CW = $clog2(W + 1);

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] pick;
    logic           pick_ok;
    logic [W-1:0]   pick_a;
    logic [W-1:0]   pick_b;
    logic [W:0]     acc;
    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic           q_1;
    logic [CW-1:0]  cnt;
    logic [W:0]     acc_next;
    logic [W-1:0]   mplier_next;
    logic           q_1_next;
    logic           accept;

    // Scan downward so the closest requester after ptr wins
    always_comb begin : rr_pick
        logic [IDW-1:0] idx;
        pick    = ptr;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick == IDW'(i)) begin
                pick_a = req_a[i*W +: W];
                pick_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && pick_ok)
            req_ready[pick] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    booth_step #(.W(W)) u_step (
        .a        (acc),
        .q        (mplier),
        .q_1      (q_1),
        .m        (mcand),
        .a_next   (acc_next),
        .q_next   (mplier_next),
        .q_1_next (q_1_next)
    );

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (cnt == CW'(1)) state_next = DONE;
            DONE:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= IDW'(NREQ - 1);
            id     <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            q_1    <= 1'b0;
            cnt    <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    mcand  <= pick_a;
                    mplier <= pick_b;
                    acc    <= '0;
                    q_1    <= 1'b0;
                    cnt    <= CW'(W);
                    id     <= pick;
                    ptr    <= pick;
                end
                RUN: begin
                    acc    <= acc_next;
                    mplier <= mplier_next;
                    q_1    <= q_1_next;
                    cnt    <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid = (state == DONE);
    assign rsp_prod  = rsp_valid ? {acc[W-1:0], mplier} : '0;
    assign rsp_id    = id;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_booth_mult_scheduler.sv
// Directed + random bench for booth_mult_scheduler with an expected-result
// queue filled on each observed accept and drained on each delivery.
module tb_booth_mult_scheduler;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [2*W-1:0] prod;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [2*W-1:0]    rsp_prod;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    exp_t sb[$];
    int   grants[$];
    int   acc_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   n_rsp  = 0;
    int   n_drop = 0;

    always #5 clk = ~clk;

    booth_mult_scheduler #(.NREQ(NREQ), .W(W), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_prod  (rsp_prod),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        return p;
    endfunction

    // Observe handshakes due at the next edge, then advance one clock
    task automatic tick();
        exp_t e;
        #1;
        chk("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
        if (!rst_n) chk("ready_in_reset", 32'(req_ready), 32'd0);
        if (|(req_valid & req_ready)) begin
            int g;
            g = 0;
            for (int i = 0; i < NREQ; i++)
                if (req_valid[i] && req_ready[i]) g = i;
            e.id   = IDW'(g);
            e.prod = ref_mul(req_a[g*W +: W], req_b[g*W +: W]);
            sb.push_back(e);
            grants.push_back(g);
            acc_cyc.push_back(cycle);
        end
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            chk("rsp_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_prod", 32'(rsp_prod), 32'(e.prod));
                chk("sb_id", 32'(rsp_id), 32'(e.id));
            end
        end
        @(posedge clk);
        #1;
        cycle++;
    endtask

    task automatic flush_sb();
        n_drop += sb.size();
        sb.delete();
    endtask

    task automatic wait_accept(input int na, output int n);
        n = 0;
        while (grants.size() == na && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic run_one(input int r, input logic [W-1:0] a,
                           input logic [W-1:0] b,
                           input logic [2*W-1:0] exp, input string tag);
        int n;
        int na;
        req_a[r*W +: W] = a;
        req_b[r*W +: W] = b;
        req_valid = NREQ'(1) << r;
        rsp_ready = 1'b0;
        na = grants.size();
        wait_accept(na, n);
        chk({tag, "_accept"}, 32'(grants.size() - na), 32'd1);
        req_valid = '0;
        wait_rsp(n);
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_prod"}, 32'(rsp_prod), 32'(exp));
        chk({tag, "_id"}, 32'(rsp_id), 32'(r));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        flush_sb();
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int na;
        int nr;
        int r;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '1;
        req_b     = '1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        tick();
        tick();
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_prod", 32'(rsp_prod), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_no_accept", 32'(grants.size()), 32'd0);
        req_valid = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        tick();

        // Single request, grant visible in the same cycle
        req_a[7:0] = 8'hF6;
        req_b[7:0] = 8'h0D;
        req_valid  = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'd1);
        run_one(0, 8'hF6, 8'h0D, 16'hFF7E, "single");
        chk("single_idle_busy", 32'(busy), 32'd0);

        run_one(1, 8'h80, 8'h80, 16'h4000, "min_min");
        run_one(2, 8'h80, 8'h7F, 16'hC080, "min_max");
        run_one(3, 8'h00, 8'hFF, 16'h0000, "zero_m1");
        run_one(0, 8'hFF, 8'hFF, 16'h0001, "m1_m1");

        // All four continuously valid, fresh pointer
        req_valid = '0;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(i * 17 - 30);
            req_b[i*W +: W] = W'(45 - i * 23);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        na = grants.size();
        n  = 0;
        while (grants.size() < na + 5 && n < 200) begin
            tick();
            n++;
        end
        chk("rr_count", 32'(grants.size() - na), 32'd5);
        if (grants.size() >= na + 5) begin
            for (int k = 0; k < 5; k++)
                chk("rr_order", 32'(grants[na+k]), 32'(k % NREQ));
            for (int k = 1; k < 5; k++)
                chk("rr_interval", 32'(acc_cyc[na+k] - acc_cyc[na+k-1]),
                    32'(W + 2));
        end
        req_valid = '0;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        chk("rr_drained", 32'(sb.size()), 32'd0);
        rsp_ready = 1'b0;

        // Backpressure: product held while another source waits
        req_a[2*W +: W] = 8'd100;
        req_b[2*W +: W] = 8'hFD;
        req_valid = 4'b0100;
        na = grants.size();
        wait_accept(na, n);
        chk("bp_accept", 32'(grants.size() - na), 32'd1);
        req_a[3*W +: W] = 8'd9;
        req_b[3*W +: W] = 8'd9;
        req_valid = 4'b1000;
        wait_rsp(n);
        chk("bp_valid", 32'(rsp_valid), 32'd1);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
            chk("bp_hold_prod", 32'(rsp_prod), 32'hFED4);
            chk("bp_hold_id", 32'(rsp_id), 32'd2);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        nr = n_rsp;
        tick();
        rsp_ready = 1'b0;
        tick();
        chk("bp_once", 32'(n_rsp - nr), 32'd1);
        chk("bp_released", 32'(rsp_valid), 32'd0);

        // Asynchronous reset in the middle of RUN
        req_a[0 +: W] = 8'd50;
        req_b[0 +: W] = 8'hF9;
        req_valid = 4'b0001;
        na = grants.size();
        wait_accept(na, n);
        req_valid = '0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_busy", 32'(busy), 32'd1);
        req_a[1*W +: W] = 8'hB3;
        req_b[1*W +: W] = 8'd55;
        req_a[2*W +: W] = 8'd3;
        req_b[2*W +: W] = 8'd4;
        req_valid = 4'b0110;
        rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(rsp_valid), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_prod", 32'(rsp_prod), 32'd0);
        chk("async_id", 32'(rsp_id), 32'd0);
        chk("async_ready", 32'(req_ready), 32'd0);
        flush_sb();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd2);
        na = grants.size();
        wait_accept(na, n);
        chk("post_rst_accept", 32'(grants.size() - na), 32'd1);
        req_valid = '0;
        wait_rsp(n);
        chk("post_rst_prod", 32'(rsp_prod), 32'hEF75);
        chk("post_rst_id", 32'(rsp_id), 32'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Random pairs, random requesters, random consumer stalls
        for (int i = 0; i < 2000; i++) begin
            r  = $urandom_range(0, NREQ - 1);
            ra = W'($urandom);
            rb = W'($urandom);
            req_a[r*W +: W] = ra;
            req_b[r*W +: W] = rb;
            req_valid = NREQ'(1) << r;
            na = grants.size();
            n  = 0;
            while (grants.size() == na && n < 200) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            chk("rand_accept", 32'(grants.size() - na), 32'd1);
            if (grants.size() > na)
                chk("rand_grant", 32'(grants[$]), 32'(r));
            req_valid = '0;
        end
        rsp_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            tick();
            n++;
        end
        rsp_ready = 1'b0;
        tick();
        chk("rand_drained", 32'(sb.size()), 32'd0);
        chk("rsp_accounting", 32'(n_rsp + n_drop), 32'(grants.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_mult_scheduler.md
# booth_mult_scheduler

Shares one iterative radix-2 Booth signed multiplier among `NREQ` requesters using round-robin arbitration and valid/ready handshakes. It accepts one operand pair at a time and runs `W` add/subtract-and-shift steps, one per clock. It then holds the 2W-bit product, tagged with the requester index, until the consumer accepts it. It sits between the lab's operand sources and a single result sink, replacing per-requester multiplier instances.

## Interface
- `NREQ`, default 4: number of requesters, at least 2.
- `W`, default 8: operand width, signed two's complement, at least 2.
- `IDW`, default `$clog2(NREQ)`: requester-index width.
- `clk` input, 1 bit: single clock, all state on rising edge.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `req_valid` input, `NREQ` bits: per-requester operand pair valid.
- `req_a` input, `NREQ*W` bits: multiplicands; slice i is `[i*W +: W]`.
- `req_b` input, `NREQ*W` bits: multipliers; same slicing.
- `req_ready` output, `NREQ` bits: one-hot grant/accept; at most one bit set.
- `rsp_valid` output, 1 bit: product available.
- `rsp_ready` input, 1 bit: consumer accepts product.
- `rsp_prod` output, `2*W` bits: signed product.
- `rsp_id` output, `IDW` bits: index of the requester that owns `rsp_prod`.
- `busy` output, 1 bit: high in RUN or DONE.

## Operation
- States:
  - IDLE: `req_ready` is combinational. It selects the first set `req_valid` bit, searching upward from `ptr+1` mod `NREQ`. An accept is `req_valid[i] && req_ready[i]` at an edge.
  - Accept edge: latch `M=a_i`, `Q=b_i`, `A=0`, `q_1=0`, `cnt=W`, `id=i`; set `ptr=i`; go to RUN.
  - RUN: each edge performs one Booth step.
    - `{Q[0],q_1}` = 10: `A-=M`. 01: `A+=M`. 00 or 11: no change.
    - Then arithmetic right shift of `{A,Q,q_1}`, sign preserved from A's MSB.
    - `cnt` decrements. On the edge where `cnt` goes 1 to 0, go to DONE.
  - DONE: `rsp_valid=1`, `rsp_prod={A,Q}[2W-1:0]`, `rsp_id=id`. These are held stable until `rsp_valid && rsp_ready` at an edge, then the block returns to IDLE.
- Width rule: A is `W+1` bits. M is sign-extended to `W+1` before add/sub. This makes `M = -2^(W-1)` correct. All add/sub wraps mod `2^(W+1)`.
- `req_ready` is 0 in RUN and DONE. There is no accept in the same edge as the DONE handshake.
- Requesters hold `req_valid` and operands stable until accepted. Dropping `req_valid` before the grant is legal; that requester is simply skipped.
- The product is correct for all `2^(2W)` operand pairs.

## Timing
- Reset (`rst_n` low, asynchronous, any state including mid-RUN):
  - State goes to IDLE and the in-flight operation is discarded.
  - `ptr=NREQ-1`, so requester 0 has first priority.
  - `rsp_valid=0`, `rsp_prod=0`, `rsp_id=0`, `busy=0`.
  - `req_ready` is forced to 0 while `rst_n` is low.
- Latency: accept at edge E0. Steps occur at E1..EW. `rsp_valid` rises after EW, i.e. `W` clocks after accept.
- Throughput with `rsp_ready` held high:
  - Handshake at E(W+1), back in IDLE.
  - Next accept at E(W+2), giving one product per `W+2` clocks.
- Backpressure: DONE may last indefinitely. New requests queue at their sources with no loss.
- Fairness:
  - The pointer updates only on accept.
  - A continuously-valid requester waits at most `NREQ-1` other products.
- Simultaneous valids in IDLE: exactly one grant, round-robin order. All others see `req_ready=0`.
- `busy` rises after E0 and falls after the DONE handshake edge.

## Structure
- Package `booth_sched_pkg`:
  - state enum {IDLE, RUN, DONE}, 2 bits;
  - Booth op encoding {NOP, ADD, SUB};
  - default `W` and `NREQ` constants.
- Sub-module `booth_step`, combinational, width `W` parameter:
  - inputs `A[W:0]`, `Q`, `q_1`, `M`;
  - outputs the next `A`, `Q`, `q_1` after add/sub plus arithmetic shift.
  - The scheduler holds the registers, FSM, arbiter and counter.
- The round-robin picker is a function or always block inside the scheduler, not a separate module.

## Test plan
- Single request, req0 `a=-10` (0xF6), `b=13` (0x0D): `req_ready[0]` in the same cycle; `rsp_valid` 8 clocks after accept; `rsp_prod=0xFF7E` (-130), `rsp_id=0`.
- Corner operands, one at a time:
  - `-128 × -128` gives `0x4000`;
  - `-128 × 127` gives `0xC080`;
  - `0 × -1` gives `0x0000`;
  - `-1 × -1` gives `0x0001`.
- All four requesters valid from reset with `rsp_ready=1`:
  - grants in order 0,1,2,3,0; a new accept every 10 clocks;
  - `rsp_id` matches each product.
- Backpressure: hold `rsp_ready=0` for 20 clocks in DONE. `rsp_prod` and `rsp_id` stay stable, `req_ready` stays 0, and the product is delivered once when `rsp_ready` rises.
- Reset asserted at step 4 of RUN: outputs clear immediately (asynchronously). After release with req1 and req2 valid, req1 is granted first (`ptr` reset) and its product is correct.
- Exhaustive random: 2000 random pairs from random requesters with random `rsp_ready` gaps. Each product equals the signed reference, no response is lost or duplicated, and grants stay one-hot.
